// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters, zero-latency
// timing decode for the renderer, and a delay-matched output stage that drives
// the sync and RGB pins with forced blanking.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int PIPE_DLY = 1
) (
    input  logic       clk_25,
    input  logic       rst,
    input  logic [3:0] rgb_r_in,
    input  logic [3:0] rgb_g_in,
    input  logic [3:0] rgb_b_in,
    output logic [9:0] sx,
    output logic [9:0] sy,
    output logic       active_pixel,
    output logic       line_start,
    output logic       frame_end,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);

    // Totals must stay <= 1024 so the 10-bit counters can hold them.
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Pin level that means "sync pulse asserted".
    localparam logic SYNC_ON = (SYNC_POL != 0);

    logic       hs_raw;
    logic       vs_raw;
    logic [2:0] tim_p0;   // {hs, vs, active} in counter time
    logic [2:0] tim_dly;  // same bits, aligned with rgb_*_in
    logic       hs_d;
    logic       vs_d;
    logic       act_d;

    // Blanking: RGB is only passed through during the visible area.
    function automatic logic [3:0] blank_rgb(input logic act, input logic [3:0] c);
        return act ? c : 4'd0;
    endfunction

    // Pixel and line counters; sy advances on the cycle sx wraps.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            sx <= '0;
            sy <= '0;
        end else if (sx == H_LAST) begin
            sx <= '0;
            sy <= (sy == V_LAST) ? 10'd0 : sy + 10'd1;
        end else begin
            sx <= sx + 10'd1;
        end
    end

    // Zero-latency timing decode straight from the counters.
    always_comb begin
        hs_raw       = (sx >= HS_BEG) && (sx <= HS_END);
        vs_raw       = (sy >= VS_BEG) && (sy <= VS_END);
        active_pixel = (sx < H_ACT) && (sy < V_ACT);
        line_start   = (sx == 10'd0);
        frame_end    = (sx == 10'd0) && (sy == V_LAST);
        tim_p0       = {hs_raw, vs_raw, active_pixel};
    end

    // Delay line matching the renderer latency; zero depth is a plain wire.
    generate
        if (PIPE_DLY == 0) begin : g_bypass
            assign tim_dly = tim_p0;
        end else begin : g_pipe
            logic [2:0] tim_p1 [PIPE_DLY];

            // Shift timing bits; reset leaves every stage blank with sync idle.
            always_ff @(posedge clk_25) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DLY; i++) tim_p1[i] <= 3'b000;
                end else begin
                    tim_p1[0] <= tim_p0;
                    for (int i = 1; i < PIPE_DLY; i++) tim_p1[i] <= tim_p1[i-1];
                end
            end

            assign tim_dly = tim_p1[PIPE_DLY-1];
        end
    endgenerate

    assign hs_d  = tim_dly[2];
    assign vs_d  = tim_dly[1];
    assign act_d = tim_dly[0];

    // Output register: polarity-corrected sync and blanked RGB onto the pins.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            vga_hs <= ~SYNC_ON;
            vga_vs <= ~SYNC_ON;
            vga_r  <= 4'd0;
            vga_g  <= 4'd0;
            vga_b  <= 4'd0;
        end else begin
            vga_hs <= hs_d ? SYNC_ON : ~SYNC_ON;
            vga_vs <= vs_d ? SYNC_ON : ~SYNC_ON;
            vga_r  <= blank_rgb(act_d, rgb_r_in);
            vga_g  <= blank_rgb(act_d, rgb_g_in);
            vga_b  <= blank_rgb(act_d, rgb_b_in);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one instance at default 640x480 timing for
// line-level behaviour and one with a tiny raster (24x15) so frame wrap,
// vsync and mid-frame reset fit in a short run. Expectations are queued with
// the cycle they are due; a monitor pops and compares them on the falling edge.
module tb_vga_timing_gen;

    logic       clk_25 = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] rgb_r_in = 4'd0;
    logic [3:0] rgb_g_in = 4'd0;
    logic [3:0] rgb_b_in = 4'd0;

    logic [9:0] d_sx, d_sy, s_sx, s_sy;
    logic       d_act, d_ls, d_fe, d_hs, d_vs;
    logic       s_act, s_ls, s_fe, s_hs, s_vs;
    logic [3:0] d_r, d_g, d_b, s_r, s_g, s_b;

    vga_timing_gen u_dflt (
        .clk_25(clk_25), .rst(rst),
        .rgb_r_in(rgb_r_in), .rgb_g_in(rgb_g_in), .rgb_b_in(rgb_b_in),
        .sx(d_sx), .sy(d_sy), .active_pixel(d_act), .line_start(d_ls),
        .frame_end(d_fe), .vga_hs(d_hs), .vga_vs(d_vs),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_POL(0),  .PIPE_DLY(1)
    ) u_small (
        .clk_25(clk_25), .rst(rst),
        .rgb_r_in(rgb_r_in), .rgb_g_in(rgb_g_in), .rgb_b_in(rgb_b_in),
        .sx(s_sx), .sy(s_sy), .active_pixel(s_act), .line_start(s_ls),
        .frame_end(s_fe), .vga_hs(s_hs), .vga_vs(s_vs),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
    );

    always #20 clk_25 = ~clk_25;

    // Signal selectors: 0..9 default instance, 10..19 small instance, 20..23 counts.
    localparam int SX = 0, SY = 1, ACT = 2, LS = 3, FE = 4, HS = 5, VS = 6, R = 7, G = 8, B = 9;
    localparam int S = 10;
    localparam int C_LS = 20, C_HSLO = 21, C_SVSLO = 22, C_SFE = 23;

    typedef struct {
        int due;
        int id;
        int val;
    } exp_t;

    exp_t exp_q[$];
    int   tick = 0;
    int   base = 0;
    bit   base_set = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ls_cnt = 0, hs_lo_cnt = 0, svs_lo_cnt = 0, sfe_cnt = 0;

    always @(posedge clk_25) tick <= tick + 1;

    function automatic int get_sig(input int id);
        case (id)
            SX:      return int'(d_sx);
            SY:      return int'(d_sy);
            ACT:     return int'(d_act);
            LS:      return int'(d_ls);
            FE:      return int'(d_fe);
            HS:      return int'(d_hs);
            VS:      return int'(d_vs);
            R:       return int'(d_r);
            G:       return int'(d_g);
            B:       return int'(d_b);
            S+SX:    return int'(s_sx);
            S+SY:    return int'(s_sy);
            S+ACT:   return int'(s_act);
            S+LS:    return int'(s_ls);
            S+FE:    return int'(s_fe);
            S+HS:    return int'(s_hs);
            S+VS:    return int'(s_vs);
            S+R:     return int'(s_r);
            S+G:     return int'(s_g);
            S+B:     return int'(s_b);
            C_LS:    return ls_cnt;
            C_HSLO:  return hs_lo_cnt;
            C_SVSLO: return svs_lo_cnt;
            C_SFE:   return sfe_cnt;
            default: return -1;
        endcase
    endfunction

    function automatic string sig_name(input int id);
        string nm [10] = '{"sx", "sy", "active_pixel", "line_start", "frame_end",
                           "vga_hs", "vga_vs", "vga_r", "vga_g", "vga_b"};
        if (id < S)      return {"dflt.", nm[id]};
        if (id < 20)     return {"small.", nm[id-S]};
        if (id == C_LS)  return "dflt.line_start_per_line";
        if (id == C_HSLO) return "dflt.hs_low_per_line";
        if (id == C_SVSLO) return "small.vs_low_per_frame";
        return "small.frame_end_per_frame";
    endfunction

    // Queue an expectation for counter cycle n after release.
    task automatic exp_c(input int n, input int id, input int val);
        exp_q.push_back('{due: base + n, id: id, val: val});
    endtask

    // Queue an expectation for the current cycle.
    task automatic exp_now(input int id, input int val);
        exp_q.push_back('{due: tick, id: id, val: val});
    endtask

    // Advance to counter cycle n, landing just after its rising edge.
    task automatic wait_to(input int n);
        while (tick - base < n) begin
            @(posedge clk_25);
            #1;
        end
    endtask

    // Monitor: window counters, then pop and compare everything due now.
    initial begin
        forever begin
            int n;
            @(negedge clk_25);
            n = tick - base;
            if (base_set) begin
                if (n >= 1 && n <= 800 && d_ls) ls_cnt++;
                if (n >= 2 && n <= 801 && !d_hs) hs_lo_cnt++;
                if (n >= 2 && n <= 361 && !s_vs) svs_lo_cnt++;
                if (n >= 1 && n <= 360 && s_fe) sfe_cnt++;
            end
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].due <= tick) begin
                    int got;
                    got = get_sig(exp_q[i].id);
                    n_checks++;
                    if (exp_q[i].due < tick) begin
                        n_errors++;
                        $display("FAIL %s: check for cycle %0d skipped at cycle %0d, expected %0d",
                                 sig_name(exp_q[i].id), exp_q[i].due - base, n, exp_q[i].val);
                    end else if (got != exp_q[i].val) begin
                        n_errors++;
                        $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                                 sig_name(exp_q[i].id), n, got, exp_q[i].val);
                    end
                    exp_q.delete(i);
                end
            end
        end
    end

    // Stimulus: reset, release, RGB pattern, mid-frame reset, re-release.
    initial begin
        repeat (3) @(posedge clk_25);
        #1;
        // Held in reset: counters at origin, pins idle and blank.
        exp_now(SX, 0);   exp_now(SY, 0);   exp_now(HS, 1);   exp_now(VS, 1);
        exp_now(R, 0);    exp_now(ACT, 1);  exp_now(LS, 1);   exp_now(FE, 0);
        exp_now(S+HS, 1); exp_now(S+VS, 1); exp_now(S+R, 0);
        @(posedge clk_25);
        #1;
        rst      = 1'b0;
        base     = tick;
        base_set = 1'b1;

        // Default instance: release, line wrap, hsync edges, blanking.
        exp_c(0, SX, 0);     exp_c(0, SY, 0);     exp_c(1, SX, 1);
        exp_c(799, SX, 799); exp_c(799, SY, 0);   exp_c(799, LS, 0);
        exp_c(800, SX, 0);   exp_c(800, SY, 1);   exp_c(800, LS, 1);
        exp_c(801, LS, 0);   exp_c(801, C_LS, 1);
        exp_c(657, HS, 1);   exp_c(658, HS, 0);   exp_c(753, HS, 0);
        exp_c(754, HS, 1);   exp_c(802, C_HSLO, 96);
        exp_c(700, VS, 1);
        exp_c(639, ACT, 1);  exp_c(640, ACT, 0);
        exp_c(2, R, 15);     exp_c(2, G, 0);      exp_c(3, R, 0);   exp_c(4, R, 15);
        exp_c(641, R, 15);   exp_c(641, B, 15);   exp_c(642, R, 0); exp_c(642, G, 0);
        exp_c(801, R, 0);    exp_c(802, R, 15);

        // Small instance: line/frame wrap, hsync, vsync, frame_end, blanking.
        exp_c(23, S+SX, 23);  exp_c(23, S+SY, 0);  exp_c(24, S+SX, 0);  exp_c(24, S+SY, 1);
        exp_c(24, S+LS, 1);   exp_c(25, S+LS, 0);
        exp_c(19, S+HS, 1);   exp_c(20, S+HS, 0);  exp_c(23, S+HS, 0);  exp_c(24, S+HS, 1);
        exp_c(241, S+VS, 1);  exp_c(242, S+VS, 0); exp_c(289, S+VS, 0); exp_c(290, S+VS, 1);
        exp_c(362, C_SVSLO, 48);
        exp_c(335, S+FE, 0);  exp_c(336, S+FE, 1); exp_c(337, S+FE, 0); exp_c(361, C_SFE, 1);
        exp_c(359, S+SX, 23); exp_c(359, S+SY, 14); exp_c(360, S+SX, 0); exp_c(360, S+SY, 0);
        exp_c(183, S+ACT, 1); exp_c(192, S+ACT, 0);
        exp_c(17, S+R, 15);   exp_c(18, S+R, 0);   exp_c(185, S+R, 15); exp_c(194, S+R, 0);

        // Mid-frame reset with the small raster inside vsync.
        exp_c(2780, S+SX, 20); exp_c(2780, S+SY, 10); exp_c(2780, S+VS, 0);
        exp_c(2780, SX, 380);  exp_c(2780, R, 15);
        exp_c(2781, S+SX, 0);  exp_c(2781, S+SY, 0);  exp_c(2781, S+VS, 1); exp_c(2781, S+HS, 1);
        exp_c(2781, SX, 0);    exp_c(2781, SY, 0);    exp_c(2781, R, 0);    exp_c(2781, S+R, 0);
        exp_c(2782, SX, 1);    exp_c(2782, S+SX, 1);  exp_c(2782, R, 0);    exp_c(2783, R, 15);

        // Single-cycle red pulse for pixel (0,0), then constant white.
        wait_to(1);
        rgb_r_in = 4'hF;
        wait_to(2);
        rgb_r_in = 4'h0;
        wait_to(3);
        rgb_r_in = 4'hF;
        rgb_g_in = 4'hF;
        rgb_b_in = 4'hF;

        wait_to(2780);
        rst = 1'b1;
        wait_to(2781);
        rst = 1'b0;
        wait_to(2790);
        @(negedge clk_25);
        #1;

        if (exp_q.size() != 0) begin
            n_checks += exp_q.size();
            n_errors += exp_q.size();
            $display("FAIL pending_checks: got %0d left in queue, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the raster timing consumed by the pixel-drawing blocks: pixel coordinates sx/sy, active_pixel, and line/frame strobes.
- Receives the RGB those blocks compute and drives the VGA pins (hsync, vsync, 4-bit R/G/B).
- Delays sync and blanking to match the renderer's pipeline latency, so the pins stay aligned.
- Default timing is 640x480@60 Hz from a 25 MHz pixel clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, 0 = sync pulses active-low, 1 = active-high
- PIPE_DLY, 1, renderer latency in clk_25 cycles from sx/sy to rgb_*_in; legal range 0..4

Ports:
- clk_25  in  1  pixel clock, 25 MHz
- rst  in  1  synchronous, active-high reset
- rgb_r_in  in  4  red from renderer, valid PIPE_DLY cycles after its sx/sy
- rgb_g_in  in  4  green, same timing as rgb_r_in
- rgb_b_in  in  4  blue, same timing as rgb_r_in
- sx  out  10  horizontal counter, 0..H_TOTAL-1
- sy  out  10  vertical counter, 0..V_TOTAL-1
- active_pixel  out  1  high when sx<H_ACTIVE and sy<V_ACTIVE
- line_start  out  1  one-cycle pulse when sx==0
- frame_end  out  1  one-cycle pulse when sx==0 and sy==V_TOTAL-1 (animation tick)
- vga_hs  out  1  horizontal sync pin
- vga_vs  out  1  vertical sync pin
- vga_r  out  4  red pin
- vga_g  out  4  green pin
- vga_b  out  4  blue pin

Behaviour:
- Derived widths: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both must be ≤1024. Counters are 10-bit unsigned.
- Reset (rst=1 at a clock edge):
  - sx=0, sy=0.
  - All pipeline stages cleared to "blank, sync deasserted".
  - vga_r/g/b=0; vga_hs=vga_vs=~SYNC_POL.
  - active_pixel, line_start and frame_end are decoded from the counters, so during reset they read 1, 1 and 0.
- Counters:
  - When sx==H_TOTAL-1, sx wraps to 0; otherwise sx increments each cycle.
  - sy increments only on the cycle sx wraps.
  - When sy==V_TOTAL-1 at an sx wrap, sy wraps to 0.
  - Frame length is exactly H_TOTAL*V_TOTAL = 420000 cycles.
- Timing-domain decode: combinational from sx/sy, zero latency.
  - hs_raw is asserted for sx in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751].
  - vs_raw is asserted for sy in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490, 491]. It covers whole lines, changing at sx==0.
  - active_pixel, line_start and frame_end follow the port definitions above.
- Alignment pipeline:
  - {hs_raw, vs_raw, active_pixel} pass through a PIPE_DLY-deep shift register.
  - With PIPE_DLY=0 the shift register is bypassed.
- Output register stage (one cycle):
  - vga_hs <= SYNC_POL ? hs_d : ~hs_d; vga_vs likewise.
  - vga_r/g/b <= act_d ? rgb_*_in : 0.
  - Pin latency from counter value to pins is PIPE_DLY+1 cycles for sync and RGB alike.
- Blanking is forced by this block: outside active_pixel the RGB pins are 0 regardless of rgb_*_in.
- Reset mid-frame: counters return to 0 on the next edge and pins blank the same edge. No partial sync pulse is extended, and timing restarts cleanly at pixel (0,0).
- Deasserting rst: sx=0/sy=0 is held for that edge; the following edge gives sx=1.
- No enable input: the counters free-run whenever rst=0.

Test Plan:
- Reset hold then release:
  - During rst: pins hs=vs=1, rgb=0, sx=sy=0.
  - First cycle after release: sx=0; the next cycle sx=1.
- Line wrap:
  - Run 800 cycles: sx goes 799->0 and sy goes 0->1 on the same edge.
  - line_start pulses exactly once per 800 cycles.
- Frame wrap:
  - Run 420000 cycles: sy=524, sx=799 -> (0,0).
  - frame_end pulses once, at sx=0, sy=524.
- Sync widths (SYNC_POL=0, PIPE_DLY=1):
  - vga_hs is low 96 cycles per line, first low at counter sx=656 +2 cycles.
  - vga_vs is low 1600 cycles, spanning sy=490..491 delayed by 2 cycles.
- Alignment and blanking:
  - Drive rgb_*_in = 4'hF constantly: pins are F only while the 2-cycle-delayed active_pixel is high, else 0.
  - A pulse on rgb_r_in at cycle t+1 for pixel sx=0/sy=0 (counter at cycle t) appears on vga_r at cycle t+2.
- Reset mid-frame: assert rst at sx=700, sy=490 (inside vsync); vga_vs returns to 1 and sx/sy=0 on the next edge.
